// File: rtl/regbank_pkg.sv
// Shared constants for the register-destination path: fixed register
// indices, the register-index type and the destination-mux selections.
package regbank_pkg;

    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0] RegIdx;

    localparam RegIdx REG_ZERO = 5'd0;
    localparam RegIdx REG_SP   = 5'd29;
    localparam RegIdx REG_RA   = 5'd31;

    // Destination-mux selections; the fixed choices resolve to REG_SP / REG_RA.
    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_SP = 2'd2;
    localparam logic [1:0] DST_RA = 2'd3;

    // Index selected by the destination mux for a given selection code.
    function automatic RegIdx dst_index(logic [1:0] sel, RegIdx rt, RegIdx rd);
        RegIdx idx;
        unique case (sel)
            DST_RT:  idx = rt;
            DST_RD:  idx = rd;
            DST_SP:  idx = REG_SP;
            default: idx = REG_RA;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/operand_latch.sv
// DATA_W-wide enable register with synchronous active-low clear, used for
// the A and B operand registers.
module operand_latch #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear on reset, capture when enabled, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_bank_wb.sv
// Write-back register bank: 32x32 storage, two combinational read ports with
// optional same-cycle forwarding, and the A/B operand registers.
module reg_bank_wb
    import regbank_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 'd227,
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_write,
    input  RegIdx             write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  RegIdx             read_reg_1,
    input  RegIdx             read_reg_2,
    input  logic              ab_load,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              wr_ack
);

    logic [DATA_W-1:0] bank [NUM_REGS];

    // A write to reg 0 is dropped; only real destinations forward.
    logic write_live;
    assign write_live = reg_write && (write_reg != REG_ZERO);

    // Bank update: reset loads SP into reg 29, everything else to zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                bank[i] <= (RegIdx'(i) == REG_SP) ? SP_RESET : '0;
            end
        end else if (write_live) begin
            bank[write_reg] <= write_data;
        end
    end

    // Acknowledge every sampled write strobe, including dropped reg-0 writes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= reg_write;
        end
    end

    // Read port 1: reg 0 reads zero, optional forwarding of the pending write.
    always_comb begin
        read_data_1 = (read_reg_1 == REG_ZERO) ? '0 : bank[read_reg_1];
        if (BYPASS && write_live && (write_reg == read_reg_1)) begin
            read_data_1 = write_data;
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        read_data_2 = (read_reg_2 == REG_ZERO) ? '0 : bank[read_reg_2];
        if (BYPASS && write_live && (write_reg == read_reg_2)) begin
            read_data_2 = write_data;
        end
    end

    // A/B take the post-forwarding read values.
    operand_latch #(
        .DATA_W (DATA_W)
    ) u_a_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ab_load),
        .d       (read_data_1),
        .q       (a_out)
    );

    operand_latch #(
        .DATA_W (DATA_W)
    ) u_b_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ab_load),
        .d       (read_data_2),
        .q       (b_out)
    );

endmodule

// File: tb/tb_reg_bank_wb.sv
// Bench for reg_bank_wb: one instance with forwarding, one without, driven by
// the same stimulus; expected values are queued when driven, checked on output.
module tb_reg_bank_wb;

    logic        clk;
    logic        reset_n;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic        ab_load;

    logic [31:0] rd1_b, rd2_b, a_b, b_b;
    logic        ack_b;
    logic [31:0] rd1_n, rd2_n, a_n, b_n;
    logic        ack_n;

    int checks = 0;
    int failures = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    logic [31:0] model [32];

    reg_bank_wb #(
        .DATA_W   (32),
        .SP_RESET (32'd227),
        .BYPASS   (1'b1)
    ) u_dut_byp (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .ab_load     (ab_load),
        .read_data_1 (rd1_b),
        .read_data_2 (rd2_b),
        .a_out       (a_b),
        .b_out       (b_b),
        .wr_ack      (ack_b)
    );

    reg_bank_wb #(
        .DATA_W   (32),
        .SP_RESET (32'd227),
        .BYPASS   (1'b0)
    ) u_dut_nob (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .ab_load     (ab_load),
        .read_data_1 (rd1_n),
        .read_data_2 (rd2_n),
        .a_out       (a_n),
        .b_out       (b_n),
        .wr_ack      (ack_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", obs, 32'hxxxx_xxxx);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_eq(t, obs, e);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
        reg_write  = 1'b1;
        write_reg  = idx;
        write_data = data;
        tick();
        if (idx != 5'd0) model[idx] = data;
        reg_write = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        read_reg_1 = 5'd0;
        read_reg_2 = 5'd0;
        ab_load    = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        model_reset();

        // 1. Reset state and full read sweep.
        sb_push("rst_a", 32'd0);
        sb_push("rst_b", 32'd0);
        sb_push("rst_ack", 32'd0);
        sb_check(a_b);
        sb_check(b_b);
        sb_check({31'd0, ack_b});
        read_reg_1 = 5'd29;
        read_reg_2 = 5'd31;
        #2;
        sb_push("rst_sp", 32'd227);
        sb_push("rst_ra", 32'd0);
        sb_check(rd1_b);
        sb_check(rd2_n);
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            sb_push("sweep_r1", model[i]);
            sb_push("sweep_r2", model[31 - i]);
            sb_check(rd1_b);
            sb_check(rd2_n);
        end

        // 2. Write reg 8, read back, one-cycle ack.
        do_write(5'd8, 32'hDEADBEEF);
        read_reg_1 = 5'd8;
        #2;
        sb_push("wr8_read", 32'hDEADBEEF);
        sb_push("wr8_ack", 32'd1);
        sb_check(rd1_b);
        sb_check({31'd0, ack_b});
        tick();
        sb_push("wr8_ack_drop", 32'd0);
        sb_check({31'd0, ack_n});

        // 3. Reg 0 protection; forwarding never applies to reg 0.
        reg_write  = 1'b1;
        write_reg  = 5'd0;
        write_data = 32'hFFFFFFFF;
        read_reg_1 = 5'd0;
        #2;
        sb_push("r0_fwd", 32'd0);
        sb_check(rd1_b);
        tick();
        reg_write = 1'b0;
        #1;
        sb_push("r0_read", 32'd0);
        sb_push("r0_ack", 32'd1);
        sb_check(rd1_b);
        sb_check({31'd0, ack_b});

        // Back-to-back writes keep ack high.
        do_write(5'd3, 32'h33);
        reg_write  = 1'b1;
        write_reg  = 5'd4;
        write_data = 32'h44;
        tick();
        model[4] = 32'h44;
        sb_push("b2b_ack", 32'd1);
        sb_check({31'd0, ack_b});
        reg_write = 1'b0;
        tick();
        sb_push("b2b_ack_drop", 32'd0);
        sb_check({31'd0, ack_b});

        // 4. Forwarding vs. plain read, and A/B capture.
        do_write(5'd5, 32'd7);
        reg_write  = 1'b1;
        write_reg  = 5'd5;
        write_data = 32'd9;
        ab_load    = 1'b1;
        read_reg_1 = 5'd5;
        read_reg_2 = 5'd5;
        #2;
        sb_push("byp_rd1", 32'd9);
        sb_push("byp_rd2", 32'd9);
        sb_push("nob_rd1", 32'd7);
        sb_push("nob_rd2", 32'd7);
        sb_check(rd1_b);
        sb_check(rd2_b);
        sb_check(rd1_n);
        sb_check(rd2_n);
        tick();
        model[5] = 32'd9;
        reg_write = 1'b0;
        ab_load   = 1'b0;
        sb_push("byp_a", 32'd9);
        sb_push("byp_b", 32'd9);
        sb_push("nob_a", 32'd7);
        sb_push("nob_b", 32'd7);
        sb_push("nob_rd1_after", 32'd9);
        sb_check(a_b);
        sb_check(b_b);
        sb_check(a_n);
        sb_check(b_n);
        sb_check(rd1_n);

        // 5. jal path: reg 31, capture into B, then hold.
        do_write(5'd31, 32'h00000104);
        ab_load    = 1'b1;
        read_reg_2 = 5'd31;
        tick();
        ab_load    = 1'b0;
        sb_push("jal_b", 32'h00000104);
        sb_push("jal_b_nob", 32'h00000104);
        sb_check(b_b);
        sb_check(b_n);
        read_reg_2 = 5'd8;
        tick();
        sb_push("jal_b_hold", 32'h00000104);
        sb_check(b_b);

        // Random writes and reads against the model.
        for (int i = 0; i < 24; i++) begin
            logic [4:0]  idx;
            logic [31:0] dat;
            idx = 5'($urandom_range(0, 31));
            dat = $urandom;
            do_write(idx, dat);
            read_reg_1 = idx;
            read_reg_2 = 5'($urandom_range(0, 31));
            #1;
            sb_push("rand_r1", model[idx]);
            sb_push("rand_r2", model[read_reg_2]);
            sb_check(rd1_b);
            sb_check(rd2_n);
        end

        // 6. Reset on the same edge as a write to reg 29 with A/B load.
        ab_load    = 1'b1;
        reg_write  = 1'b1;
        write_reg  = 5'd29;
        write_data = 32'd5;
        reset_n    = 1'b0;
        tick();
        reset_n   = 1'b1;
        reg_write = 1'b0;
        ab_load   = 1'b0;
        model_reset();
        read_reg_1 = 5'd29;
        read_reg_2 = 5'd8;
        #1;
        sb_push("mid_rst_sp", 32'd227);
        sb_push("mid_rst_r8", 32'd0);
        sb_push("mid_rst_a", 32'd0);
        sb_push("mid_rst_b", 32'd0);
        sb_push("mid_rst_ack", 32'd0);
        sb_check(rd1_b);
        sb_check(rd2_b);
        sb_check(a_b);
        sb_check(b_n);
        sb_check({31'd0, ack_b});

        if (exp_q.size() != 0) check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- Write-back end of the register-destination path in the multicycle MIPS datapath.
- Consumes the 5-bit destination chosen by the destination mux (rt, rd, reg 29 or reg 31) together with the write-back data, and stores it in a 32x32 register bank.
- Serves two combinational read ports (rs, rt).
- Latches the read values into the A/B operand registers for the next datapath stage.

Parameters:
- DATA_W, 32, register word width.
- SP_RESET, 32'd227, reset value of reg 29 (stack pointer).
- BYPASS, 1, 1 = write-to-read forwarding on the read ports; 0 = plain read of stored value.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- reg_write  in  1  write strobe from control unit.
- write_reg  in  5  destination index (from destination mux: rt / rd / 29 / 31).
- write_data  in  DATA_W  write-back value (ALUOut / MDR / PC / HI / LO, selected upstream).
- read_reg_1  in  5  rs index.
- read_reg_2  in  5  rt index.
- ab_load  in  1  load enable for the A/B operand registers.
- read_data_1  out  DATA_W  combinational value of read_reg_1.
- read_data_2  out  DATA_W  combinational value of read_reg_2.
- a_out  out  DATA_W  registered operand A.
- b_out  out  DATA_W  registered operand B.
- wr_ack  out  1  one-cycle pulse the cycle after a write is committed.

Behaviour:
Reset (reset_n = 0 at a rising edge):
- All registers clear to 0, except reg 29, which loads SP_RESET.
- a_out, b_out and wr_ack clear to 0.
- Reset overrides reg_write and ab_load in the same cycle.
- Reset asserted mid-sequence discards any pending write.

Write:
- Commits on a rising edge when reg_write = 1 and reset_n = 1.
- bank[write_reg] <= write_data; latency is one edge.
- write_reg = 0: the write is dropped, reg 0 stays 0 permanently, and wr_ack is still pulsed (the control unit must not stall on it).
- wr_ack = 1 for exactly the cycle after any edge that sampled reg_write = 1. Back-to-back writes give a continuous wr_ack high.

Read:
- Purely combinational from the current bank contents.
- Index 0 always returns 0.
- BYPASS = 1: if reg_write = 1, write_reg = read_reg_N and write_reg != 0, then read_data_N = write_data (same-cycle forwarding).
- BYPASS = 0: the old value is returned until the edge.
- Both ports may address the same register; both forward identically.

Operand registers:
- On an edge with ab_load = 1: a_out <= read_data_1 and b_out <= read_data_2, taking post-bypass values.
- With ab_load = 1 and reg_write = 1 to the same index in the same cycle:
  - BYPASS = 1: A/B capture the new data.
  - BYPASS = 0: A/B capture the old data.
- ab_load = 0: A/B hold their values.

Width rules:
- Indices are 5-bit unsigned; all 32 indices are valid, so there are no out-of-range cases.
- Data is stored unmodified; no sign handling.

State:
- No FSM.
- State consists of the bank, the A/B registers and the wr_ack flop.

Decomposition:
- Shared package (regbank_pkg):
  - REG_ZERO = 5'd0, REG_SP = 5'd29, REG_RA = 5'd31.
  - NUM_REGS = 32.
  - RegIdx type (5-bit).
  - The same constants the destination mux uses for its fixed selections.
- Sub-module: operand_latch (DATA_W-wide enable register with synchronous active-low clear), instantiated twice for A and B.
- The bank itself stays inline.

Test Plan:
1. Reset then read: read_reg_1 = 29, read_reg_2 = 31 -> read_data_1 = 227, read_data_2 = 0. Every other index reads 0.
2. Write rd path: reg_write = 1, write_reg = 8, write_data = 32'hDEADBEEF. Next cycle read_reg_1 = 8 -> 32'hDEADBEEF, and wr_ack = 1 for one cycle.
3. Reg 0 protection: write_reg = 0, write_data = 32'hFFFFFFFF -> reg 0 reads 0, and wr_ack still pulses.
4. Bypass with BYPASS = 1: reg 5 = 7, then same cycle reg_write = 1, write_reg = 5, data = 9, ab_load = 1, read_reg_1 = 5. Expect read_data_1 = 9 combinationally and a_out = 9 after the edge. With BYPASS = 0: read_data_1 = 7 and a_out = 7.
5. jal path: write_reg = 31, write_data = 32'h00000104; then ab_load = 1 with read_reg_2 = 31 -> b_out = 32'h00000104. With ab_load = 0 the following cycle, b_out holds its value.
6. Reset mid-operation: reset_n = 0 on the same edge as a write to 29 with value 5 -> reg 29 = 227, a_out = b_out = 0, wr_ack = 0.
